// File: rtl/data_mem_pkg.sv
// Shared definitions for the data-memory request controller: FSM state encoding,
// access-size codes and the default data-segment base address.
package data_mem_pkg;

    // Byte address that maps onto RAM word 0
    localparam logic [31:0] DATA_SEG_BASE_DEFAULT = 32'h1001_0000;

    // Request size codes (2'b11 is never legal)
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRead,
        StWait,
        StResp,
        StRmwRead,
        StRmwWait,
        StRmwWrite
    } state_e;

endpackage

// File: rtl/data_mem_addr_decode.sv
// Combinational request decode: maps a MIPS byte address to a RAM word index and
// flags out-of-range, misaligned or unsupported-size requests.
// Build option: DATA_MEM_SUBWORD_STORE_EN allows byte/half sizes; without it only
// word accesses are legal.
module data_mem_addr_decode
    import data_mem_pkg::*;
#(
    parameter int unsigned           MEMORY_DEPTH  = 32,
    parameter int unsigned           DATA_WIDTH    = 32,
    parameter logic [DATA_WIDTH-1:0] DATA_SEG_BASE = DATA_SEG_BASE_DEFAULT
) (
    input  logic [DATA_WIDTH-1:0] addr_i,
    input  logic [1:0]            size_i,
    output logic [DATA_WIDTH-1:0] word_index_o,
    output logic                  err_o
);

    logic [DATA_WIDTH-1:0] offset;
    logic                  below_base;
    logic                  beyond_end;
    logic                  misaligned;
    logic                  size_bad;

    // Range, alignment and size checks on the incoming request
    always_comb begin
        offset       = addr_i - DATA_SEG_BASE;
        word_index_o = offset >> 2;
        below_base   = addr_i < DATA_SEG_BASE;
        beyond_end   = word_index_o >= DATA_WIDTH'(MEMORY_DEPTH);

        misaligned = 1'b0;
        case (size_i)
            SZ_HALF: misaligned = addr_i[0];
            SZ_WORD: misaligned = (addr_i[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase

`ifdef DATA_MEM_SUBWORD_STORE_EN
        size_bad = (size_i == 2'b11);
`else
        size_bad = (size_i != SZ_WORD);
`endif

        err_o = below_base | beyond_end | misaligned | size_bad;
    end

endmodule

// File: rtl/data_mem_access_ctrl.sv
// Request-side controller in front of the single-port synchronous data RAM.
// Accepts one load/store at a time, drives the RAM, hides its one-cycle read
// latency and returns a response over a valid/ready handshake.
// Build option: DATA_MEM_SUBWORD_STORE_EN enables byte/half stores through a
// read-modify-write sequence (byte/half loads then return the full word).
module data_mem_access_ctrl
    import data_mem_pkg::*;
#(
    parameter int unsigned           MEMORY_DEPTH  = 32,
    parameter int unsigned           DATA_WIDTH    = 32,
    parameter logic [DATA_WIDTH-1:0] DATA_SEG_BASE = DATA_SEG_BASE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [1:0]            req_size_i,
    input  logic [DATA_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic                  resp_err_o,
    output logic                  ram_write_enable_o,
    output logic [DATA_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_write_data_o,
    input  logic [DATA_WIDTH-1:0] ram_read_data_i
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] ram_addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic [1:0]            size_q;
    logic [1:0]            lane_q;

    logic [DATA_WIDTH-1:0] dec_index;
    logic                  dec_err;
    logic                  accept;

    // Insert the LSB-aligned byte/half store data into the addressed lane of old_word
    function automatic logic [DATA_WIDTH-1:0] merge_lane(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_data,
        input logic [1:0]            size,
        input logic [1:0]            lane
    );
        logic [DATA_WIDTH-1:0] mask;
        logic [4:0]            shamt;
        mask  = (size == SZ_BYTE) ? DATA_WIDTH'(8'hFF) :
                (size == SZ_HALF) ? DATA_WIDTH'(16'hFFFF) : '1;
        shamt = {lane, 3'b000};
        return (old_word & ~(mask << shamt)) | ((new_data & mask) << shamt);
    endfunction

    data_mem_addr_decode #(
        .MEMORY_DEPTH  (MEMORY_DEPTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .DATA_SEG_BASE (DATA_SEG_BASE)
    ) u_addr_decode (
        .addr_i       (req_addr_i),
        .size_i       (req_size_i),
        .word_index_o (dec_index),
        .err_o        (dec_err)
    );

    assign accept = req_valid_i & (state_q == StIdle);

    // State register; reset aborts any in-flight transaction
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    if (dec_err) begin
                        state_d = StResp;
                    end else if (!req_write_i) begin
                        state_d = StRead;
`ifdef DATA_MEM_SUBWORD_STORE_EN
                    end else if (req_size_i != SZ_WORD) begin
                        state_d = StRmwRead;
`endif
                    end else begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite:    state_d = StResp;
            StRead:     state_d = StWait;
            StWait:     state_d = StResp;
            StRmwRead:  state_d = StRmwWait;
            StRmwWait:  state_d = StRmwWrite;
            StRmwWrite: state_d = StResp;
            StResp:     if (resp_ready_i) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Datapath registers: capture request at accept, load data in WAIT, merged word in RMW_WAIT
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_addr_q <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            size_q     <= SZ_BYTE;
            lane_q     <= 2'b00;
        end else begin
            if (accept) begin
                err_q   <= dec_err;
                rdata_q <= '0;
                size_q  <= req_size_i;
                lane_q  <= req_addr_i[1:0];
                // An erroring request never touches the RAM-side registers
                if (!dec_err) begin
                    ram_addr_q <= dec_index;
                    if (req_write_i) begin
                        wdata_q <= req_wdata_i;
                    end
                end
            end
            if (state_q == StWait) begin
                rdata_q <= ram_read_data_i;
            end
            if (state_q == StRmwWait) begin
                wdata_q <= merge_lane(ram_read_data_i, wdata_q, size_q, lane_q);
            end
        end
    end

    // Outputs decoded from registered state
    always_comb begin
        req_ready_o        = (state_q == StIdle);
        resp_valid_o       = (state_q == StResp);
        ram_write_enable_o = (state_q == StWrite) || (state_q == StRmwWrite);
        resp_rdata_o       = rdata_q;
        resp_err_o         = err_q;
        ram_addr_o         = ram_addr_q;
        ram_write_data_o   = wdata_q;
    end

endmodule

// File: tb/tb_data_mem_access_ctrl.sv
// Self-checking bench for data_mem_access_ctrl: a behavioural RAM sits behind the
// controller, a word-array reference model predicts every transaction, and one
// negedge compare process checks the DUT outputs each cycle.
module tb_data_mem_access_ctrl;

    localparam logic [31:0] BASE  = 32'h1001_0000;
    localparam int          DEPTH = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid_i, req_ready_o, req_write_i;
    logic [1:0]  req_size_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic        resp_valid_o, resp_ready_i, resp_err_o;
    logic [31:0] resp_rdata_o;
    logic        ram_write_enable_o;
    logic [31:0] ram_addr_o, ram_write_data_o, ram_read_data_i;

    always #5 clk = ~clk;

    data_mem_access_ctrl dut (
        .clk                (clk),
        .reset              (reset),
        .req_valid_i        (req_valid_i),
        .req_ready_o        (req_ready_o),
        .req_write_i        (req_write_i),
        .req_size_i         (req_size_i),
        .req_addr_i         (req_addr_i),
        .req_wdata_i        (req_wdata_i),
        .resp_valid_o       (resp_valid_o),
        .resp_ready_i       (resp_ready_i),
        .resp_rdata_o       (resp_rdata_o),
        .resp_err_o         (resp_err_o),
        .ram_write_enable_o (ram_write_enable_o),
        .ram_addr_o         (ram_addr_o),
        .ram_write_data_o   (ram_write_data_o),
        .ram_read_data_i    (ram_read_data_i)
    );

    // Behavioural single-port synchronous RAM
    bit [31:0] ram [DEPTH];
    always @(posedge clk) begin
        if (ram_write_enable_o) ram[ram_addr_o[4:0]] <= ram_write_data_o;
        ram_read_data_i <= ram[ram_addr_o[4:0]];
    end

    // Reference memory contents as seen by the CPU
    bit [31:0] ref_mem [DEPTH];

    // Per-cycle expectations, written only by the stimulus process
    bit        chk_en = 1'b0;
    bit        exp_ready, exp_valid, exp_we, exp_err;
    bit        chk_resp, chk_addr, chk_wdata;
    bit [31:0] exp_rdata, exp_addr, exp_wdata;

    // Literal checks handed to the compare process
    string     lit_name;
    bit [31:0] lit_act, lit_exp;
    int        lit_seq  = 0;
    int        lit_done = 0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Single compare process
    always begin
        @(negedge clk);
        if (chk_en) begin
            cmp("req_ready", 32'(req_ready_o), 32'(exp_ready));
            cmp("resp_valid", 32'(resp_valid_o), 32'(exp_valid));
            cmp("ram_we", 32'(ram_write_enable_o), 32'(exp_we));
            if (chk_resp) begin
                cmp("resp_err", 32'(resp_err_o), 32'(exp_err));
                cmp("resp_rdata", resp_rdata_o, exp_rdata);
            end
            if (chk_addr) cmp("ram_addr", ram_addr_o, exp_addr);
            if (chk_wdata) cmp("ram_wdata", ram_write_data_o, exp_wdata);
        end
        if (lit_seq != lit_done) begin
            cmp(lit_name, lit_act, lit_exp);
            lit_done = lit_seq;
        end
    end

    task automatic lit_check(input string name, input bit [31:0] act, input bit [31:0] exp);
        lit_name = name;
        lit_act  = act;
        lit_exp  = exp;
        lit_seq++;
        @(posedge clk); #1;
    endtask

    task automatic set_idle_exp();
        exp_ready = 1'b1; exp_valid = 1'b0; exp_we = 1'b0;
        chk_resp = 1'b0; chk_addr = 1'b0; chk_wdata = 1'b0;
    endtask

    task automatic drive_junk(input bit en);
        // A legal load that must be ignored while the controller is busy
        req_valid_i = en ? 1'($urandom_range(0, 1)) : 1'b0;
        req_write_i = 1'b0;
        req_size_i  = 2'b10;
        req_addr_i  = BASE;
        req_wdata_i = $urandom;
    endtask

    // One transaction; hold<0 picks a random response back-pressure, rst_at>0
    // asserts reset in that cycle after acceptance
    task automatic run_txn(input bit wr, input bit [1:0] sz, input bit [31:0] addr,
                           input bit [31:0] wd, input int hold, input int rst_at,
                           output bit [31:0] got_rdata, output bit got_err);
        bit [31:0] off, new_word, m_rdata;
        bit        m_err;
        int        idx, lat, we_cyc, hold_n;

        off   = addr - BASE;
        idx   = int'(off / 4);
        m_err = (addr < BASE) || (off / 4 >= DEPTH) || (sz == 2'd3) ||
                (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0);
`ifndef DATA_MEM_SUBWORD_STORE_EN
        if (sz != 2'd2) m_err = 1'b1;
`endif
        new_word = 32'h0;
        m_rdata  = 32'h0;
        if (!m_err) begin
            new_word = ref_mem[idx];
            for (int b = 0; b < (1 << sz); b++)
                new_word[(int'(addr[1:0]) + b) * 8 +: 8] = wd[b * 8 +: 8];
            if (!wr) m_rdata = ref_mem[idx];
        end
        lat    = m_err ? 1 : (!wr ? 3 : (sz == 2'd2 ? 2 : 4));
        we_cyc = (wr && !m_err) ? lat - 1 : 0;
        hold_n = (hold < 0) ? int'($urandom_range(0, 3)) : hold;
        got_rdata = 32'h0;
        got_err   = 1'b0;

        // Cycle N: request offered and accepted
        req_valid_i = 1'b1; req_write_i = wr; req_size_i = sz;
        req_addr_i = addr; req_wdata_i = wd; resp_ready_i = 1'b0;
        set_idle_exp();
        chk_en = 1'b1;
        @(posedge clk); #1;

        for (int k = 1; k < lat; k++) begin
            if (k == rst_at) reset = 1'b1;
            drive_junk(k != rst_at);
            exp_ready = 1'b0; exp_valid = 1'b0; exp_we = (k == we_cyc);
            chk_resp = 1'b0;
            chk_addr = 1'b1; exp_addr = 32'(idx);
            chk_wdata = wr && (sz == 2'd2 || k == we_cyc); exp_wdata = new_word;
            @(posedge clk); #1;
            if (k == rst_at) begin
                reset = 1'b0;
                req_valid_i = 1'b0;
                set_idle_exp();
                chk_resp = 1'b1; exp_err = 1'b0; exp_rdata = 32'h0;
                chk_addr = 1'b1; exp_addr = 32'h0;
                chk_wdata = 1'b1; exp_wdata = 32'h0;
                @(posedge clk); #1;
                set_idle_exp();
                return;
            end
        end

        // Response phase: outputs must hold steady until taken
        for (int h = 0; h <= hold_n; h++) begin
            exp_ready = 1'b0; exp_valid = 1'b1; exp_we = 1'b0;
            chk_resp = 1'b1; exp_err = m_err; exp_rdata = m_rdata;
            chk_addr = !m_err; exp_addr = 32'(idx);
            chk_wdata = wr && !m_err; exp_wdata = new_word;
            resp_ready_i = (h == hold_n);
            drive_junk(h != hold_n);
            if (h == 0) begin
                got_rdata = resp_rdata_o;
                got_err   = resp_err_o;
            end
            @(posedge clk); #1;
        end
        resp_ready_i = 1'b0;
        req_valid_i  = 1'b0;
        if (!m_err && wr) ref_mem[idx] = new_word;

        set_idle_exp();
        @(posedge clk); #1;
    endtask

    bit [31:0] got_d, r_addr;
    bit        got_e;
    bit [1:0]  r_sz;

    initial begin
        reset = 1'b1;
        req_valid_i = 1'b0; req_write_i = 1'b0; req_size_i = 2'b00;
        req_addr_i = 32'h0; req_wdata_i = 32'h0; resp_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        set_idle_exp();
        chk_resp = 1'b1; exp_err = 1'b0; exp_rdata = 32'h0;
        chk_addr = 1'b1; exp_addr = 32'h0;
        chk_wdata = 1'b1; exp_wdata = 32'h0;
        chk_en = 1'b1;
        @(posedge clk); #1;
        set_idle_exp();

        // Word store then load at the segment base
        run_txn(1'b1, 2'd2, 32'h1001_0000, 32'hFFFF_FFFF, 0, 0, got_d, got_e);
        lit_check("t1_err", 32'(got_e), 32'h0);
        run_txn(1'b0, 2'd2, 32'h1001_0000, 32'h0, 0, 0, got_d, got_e);
        lit_check("t2_rdata", got_d, 32'hFFFF_FFFF);

        // Range boundaries
        run_txn(1'b1, 2'd2, 32'h1234_5678, 32'hDEAD_BEEF, 0, 0, got_d, got_e);
        lit_check("t3_far_err", 32'(got_e), 32'h1);
        run_txn(1'b1, 2'd2, 32'h1001_0080, 32'hDEAD_BEEF, 0, 0, got_d, got_e);
        lit_check("t3_end_err", 32'(got_e), 32'h1);
        run_txn(1'b1, 2'd2, 32'h1001_007C, 32'hCAFE_F00D, 0, 0, got_d, got_e);
        lit_check("t3_last_err", 32'(got_e), 32'h0);
        run_txn(1'b0, 2'd2, 32'h1001_007C, 32'h0, 1, 0, got_d, got_e);
        lit_check("t3_last_rdata", got_d, 32'hCAFE_F00D);

        // Misaligned word load with three cycles of back-pressure
        run_txn(1'b0, 2'd2, 32'h1001_0002, 32'h0, 3, 0, got_d, got_e);
        lit_check("t4_err", 32'(got_e), 32'h1);

        // Byte store into an existing word
        run_txn(1'b1, 2'd2, 32'h1001_0004, 32'h1122_3344, 0, 0, got_d, got_e);
        run_txn(1'b1, 2'd0, 32'h1001_0005, 32'h0000_00AB, 0, 0, got_d, got_e);
`ifdef DATA_MEM_SUBWORD_STORE_EN
        lit_check("t5_byte_err", 32'(got_e), 32'h0);
        run_txn(1'b0, 2'd2, 32'h1001_0004, 32'h0, 0, 0, got_d, got_e);
        lit_check("t5_rdata", got_d, 32'h1122_AB44);
`else
        lit_check("t5_byte_err", 32'(got_e), 32'h1);
        run_txn(1'b0, 2'd2, 32'h1001_0004, 32'h0, 0, 0, got_d, got_e);
        lit_check("t5_rdata", got_d, 32'h1122_3344);
`endif

        // Reset during the WAIT cycle of a load
        run_txn(1'b0, 2'd2, 32'h1001_0000, 32'h0, 0, 2, got_d, got_e);
        run_txn(1'b0, 2'd2, 32'h1001_0000, 32'h0, 0, 0, got_d, got_e);
        lit_check("t6_after_rst", got_d, 32'hFFFF_FFFF);

        // Randomised traffic
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 9))
                0:       r_addr = $urandom;
                1:       r_addr = BASE - 32'($urandom_range(1, 16));
                default: r_addr = BASE + 32'($urandom_range(0, 'h9F));
            endcase
            r_sz = ($urandom_range(0, 9) < 6) ? 2'd2 : 2'($urandom_range(0, 3));
            if (r_sz == 2'd2 && $urandom_range(0, 3) != 0) r_addr[1:0] = 2'b00;
            run_txn(1'($urandom_range(0, 1)), r_sz, r_addr, $urandom, -1, 0, got_d, got_e);
        end

        chk_en = 1'b0;
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
